// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and default timing constants
// for the stopwatch control slice.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    ADJUST = 2'd3
  } sw_state_e;

  typedef struct packed {
    logic start;
    logic pause;
    logic clear;
    logic adj_sec;
    logic adj_min;
  } sw_btn_t;

  localparam int DEF_DB_CYCLES     = 1_000_000;
  localparam int DEF_TICK_CYCLES   = 100_000_000;
  localparam int DEF_REPEAT_CYCLES = 25_000_000;

  // $clog2 that never yields a zero-width counter
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Raw button levels in, FSM state and
// counter-enable pulses out.
interface stopwatch_ctrl_if;

  logic       start_raw;
  logic       pause_raw;
  logic       clear_raw;
  logic       adj_sec_raw;
  logic       adj_min_raw;
  logic [1:0] state_o;
  logic       run_o;
  logic       tick_o;
  logic       clear_o;
  logic       inc_sec_o;
  logic       inc_min_o;

  modport master (
    output start_raw, pause_raw, clear_raw,
    output adj_sec_raw, adj_min_raw,
    input  state_o, run_o, tick_o, clear_o,
    input  inc_sec_o, inc_min_o
  );

  modport slave (
    input  start_raw, pause_raw, clear_raw,
    input  adj_sec_raw, adj_min_raw,
    output state_o, run_o, tick_o, clear_o,
    output inc_sec_o, inc_min_o
  );

endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a
// stability-window debouncer.
module sw_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic db
);

  localparam int CW = cw(DB_CYCLES);
  localparam logic [CW-1:0] TOP =
    CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // cnt is the run length of s2 disagreeing with db
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == TOP) begin
        cnt <= '0;
        db  <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Debounced button FSM producing tick, clear
// and adjust pulses for the time counter.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int TICK_CYCLES   = DEF_TICK_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input logic             clk,
  input logic             rstn,
  stopwatch_ctrl_if.slave sw
);

  localparam int PW = cw(TICK_CYCLES);
  localparam int RW = cw(REPEAT_CYCLES);
  localparam logic [PW-1:0] PTOP =
    PW'(TICK_CYCLES - 1);
  localparam logic [RW-1:0] RTOP =
    RW'(REPEAT_CYCLES - 1);

  sw_btn_t   raw;
  sw_btn_t   db;
  logic      start_q;
  logic      clear_q;
  logic      start_edge;
  logic      clear_edge;
  logic      any_adj;
  sw_state_e state;
  logic [PW-1:0] pres;
  logic [RW-1:0] rep;
  logic      tick_q;
  logic      clr_q;
  logic      isec_q;
  logic      imin_q;

  assign raw = {sw.start_raw, sw.pause_raw,
                sw.clear_raw, sw.adj_sec_raw,
                sw.adj_min_raw};

  for (genvar i = 0; i < 5; i++) begin : g_db
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .rstn (rstn),
      .raw  (raw[i]),
      .db   (db[i])
    );
  end

  assign start_edge = db.start & ~start_q;
  assign clear_edge = db.clear & ~clear_q;
  assign any_adj    = db.adj_sec | db.adj_min;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      pres    <= '0;
      rep     <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      isec_q  <= 1'b0;
      imin_q  <= 1'b0;
    end else begin
      start_q <= db.start;
      clear_q <= db.clear;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      isec_q  <= 1'b0;
      imin_q  <= 1'b0;
      if (clear_edge) begin
        state <= IDLE;
        clr_q <= 1'b1;
        pres  <= '0;
        rep   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            pres <= '0;
            rep  <= '0;
            if (start_edge) state <= RUN;
          end
          RUN: begin
            rep <= '0;
            if (pres == PTOP) begin
              pres   <= '0;
              tick_q <= 1'b1;
            end else begin
              pres <= pres + 1'b1;
            end
            if (db.pause) state <= PAUSE;
          end
          PAUSE: begin
            rep <= '0;
            if (!db.pause) state <= RUN;
            else if (any_adj) state <= ADJUST;
          end
          ADJUST: begin
            // leaving wins over a due repeat pulse
            if (!db.pause) begin
              state <= RUN;
              rep   <= '0;
            end else if (!any_adj) begin
              state <= PAUSE;
              rep   <= '0;
            end else begin
              if (rep == '0) begin
                isec_q <= db.adj_sec;
                imin_q <= ~db.adj_sec;
              end
              rep <= (rep == RTOP) ? '0
                                   : rep + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign sw.state_o   = state;
  assign sw.run_o     = (state == RUN);
  assign sw.tick_o    = tick_q;
  assign sw.clear_o   = clr_q;
  assign sw.inc_sec_o = isec_q;
  assign sw.inc_min_o = imin_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, corner
// sequences and random stimulus vs a model.
module tb_stopwatch_ctrl;

  localparam int DB = 4;
  localparam int TK = 10;
  localparam int RP = 8;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(
    .DB_CYCLES     (DB),
    .TICK_CYCLES   (TK),
    .REPEAT_CYCLES (RP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .sw   (sw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // raw bit order: start pause clear adj_sec adj_min
  logic [4:0] hist[$];
  logic [4:0] m_db;
  logic [4:0] m_dbp;
  int   m_st;
  int   m_run;
  int   m_adj;
  logic m_tick, m_clr, m_isec, m_imin;

  function automatic logic [4:0] cur_raw();
    return {sw.start_raw, sw.pause_raw,
            sw.clear_raw, sw.adj_sec_raw,
            sw.adj_min_raw};
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++)
      hist.push_back(5'b0);
    m_db  = '0;
    m_dbp = '0;
    m_st  = 0;
    m_run = 0;
    m_adj = 0;
    m_tick = 0; m_clr = 0;
    m_isec = 0; m_imin = 0;
  endtask

  task automatic model_edge();
    logic [4:0] nd;
    logic se, ce, pz, aj, same;
    int top;
    se = m_db[4] & ~m_dbp[4];
    ce = m_db[2] & ~m_dbp[2];
    pz = m_db[3];
    aj = m_db[1] | m_db[0];
    m_tick = 0; m_clr = 0;
    m_isec = 0; m_imin = 0;
    if (ce) begin
      m_st = 0; m_clr = 1;
      m_run = 0; m_adj = 0;
    end else begin
      case (m_st)
        0: begin
          m_run = 0;
          if (se) m_st = 1;
        end
        1: begin
          m_run++;
          if (m_run % TK == 0) m_tick = 1;
          if (pz) m_st = 2;
        end
        2: begin
          m_adj = 0;
          if (!pz) m_st = 1;
          else if (aj) m_st = 3;
        end
        default: begin
          if (!pz) m_st = 1;
          else if (!aj) m_st = 2;
          else begin
            if (m_adj % RP == 0) begin
              if (m_db[1]) m_isec = 1;
              else m_imin = 1;
            end
            m_adj++;
          end
        end
      endcase
    end
    // debounced value follows the raw level seen
    // two edges late once it held for DB samples
    hist.push_back(cur_raw());
    top = hist.size() - 3;
    nd = m_db;
    for (int b = 0; b < 5; b++) begin
      same = 1;
      for (int k = 0; k < DB; k++)
        if (hist[top-k][b] != hist[top][b])
          same = 0;
      if (same) nd[b] = hist[top][b];
    end
    while (hist.size() > DB + 3)
      void'(hist.pop_front());
    m_dbp = m_db;
    m_db  = nd;
  endtask

  function automatic int outs();
    logic [6:0] v;
    v = {sw.state_o, sw.run_o, sw.tick_o,
         sw.clear_o, sw.inc_sec_o, sw.inc_min_o};
    return int'(v);
  endfunction

  function automatic int exp_outs();
    logic [6:0] v;
    v = {2'(m_st), (m_st == 1), m_tick,
         m_clr, m_isec, m_imin};
    return int'(v);
  endfunction

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", outs(), exp_outs());
  endtask

  task automatic drive(input logic [4:0] v);
    sw.start_raw   = v[4];
    sw.pause_raw   = v[3];
    sw.clear_raw   = v[2];
    sw.adj_sec_raw = v[1];
    sw.adj_min_raw = v[0];
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    chk("reset_outputs", outs(), 0);
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic [4:0] raw;
    logic [7:0] hold;
    logic [1:0] st;
  } vec_t;

  vec_t vec[11];

  initial begin
    int n, run_at, mins, bad, pulses, moved;
    int tq[$];
    logic [4:0] v;
    n_checks = 0;
    n_errors = 0;
    vec = '{
      '{5'b00000, 8'd3, 2'd0},
      '{5'b01000, 8'd8, 2'd0},
      '{5'b00000, 8'd8, 2'd0},
      '{5'b10000, 8'd8, 2'd1},
      '{5'b00000, 8'd8, 2'd1},
      '{5'b01000, 8'd8, 2'd2},
      '{5'b01001, 8'd8, 2'd3},
      '{5'b01000, 8'd8, 2'd2},
      '{5'b00000, 8'd8, 2'd1},
      '{5'b00100, 8'd8, 2'd0},
      '{5'b00000, 8'd8, 2'd0}
    };
    drive(5'b0);
    rstn = 1'b1;
    model_reset();
    #1;
    do_reset();

    foreach (vec[i]) begin
      drive(vec[i].raw);
      repeat (int'(vec[i].hold)) step();
      chk("table_state", int'(sw.state_o),
          int'(vec[i].st));
    end

    // start latency and tick cadence
    do_reset();
    drive(5'b10000);
    run_at = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 13) drive(5'b0);
      step();
      if (sw.state_o == 2'd1 && run_at < 0)
        run_at = k;
      if (sw.tick_o) tq.push_back(k);
    end
    chk("start_latency", run_at, 7);
    chk("tick_count", tq.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("tick_at", (i < tq.size()) ? tq[i] : -1,
          17 + 10 * i);

    // pause keeps fractional second
    n = 0;
    while (!sw.tick_o && n < 20) begin
      step(); n++;
    end
    chk("pause_sync_tick", int'(sw.tick_o), 1);
    repeat (8) step();
    drive(5'b01000);
    bad = 0;
    repeat (30) begin
      step();
      if (sw.state_o == 2'd2 && sw.tick_o) bad++;
    end
    chk("pause_state", int'(sw.state_o), 2);
    chk("tick_in_pause", bad, 0);
    drive(5'b0);
    n = 0;
    while (sw.state_o != 2'd1 && n < 20) begin
      step(); n++;
    end
    chk("resume_latency", n, 7);
    n = 0;
    while (!sw.tick_o && n < 20) begin
      step(); n++;
    end
    chk("resume_tick", n, 5);

    // adjust with both buttons held
    drive(5'b01000);
    n = 0;
    while (sw.state_o != 2'd2 && n < 20) begin
      step(); n++;
    end
    chk("to_pause", int'(sw.state_o), 2);
    drive(5'b01011);
    n = 0;
    while (sw.state_o != 2'd3 && n < 20) begin
      step(); n++;
    end
    chk("adj_entry", int'(sw.state_o), 3);
    tq.delete();
    mins = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (sw.inc_sec_o) tq.push_back(k);
      if (sw.inc_min_o) mins++;
    end
    chk("inc_sec_count", tq.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("inc_sec_at", (i < tq.size()) ? tq[i] : -1,
          1 + 8 * i);
    chk("inc_min_quiet", mins, 0);

    // clear out of adjust
    drive(5'b01111);
    n = 0;
    while (!sw.clear_o && n < 20) begin
      step(); n++;
    end
    chk("clear_latency", n, 7);
    chk("clear_state", int'(sw.state_o), 0);
    drive(5'b01011);
    pulses = 0;
    repeat (10) begin
      step();
      pulses += int'(sw.clear_o) +
                int'(sw.inc_sec_o) +
                int'(sw.inc_min_o);
    end
    chk("post_clear_pulses", pulses, 0);

    // asynchronous reset in RUN
    drive(5'b0);
    repeat (8) step();
    drive(5'b10000);
    repeat (8) step();
    drive(5'b0);
    repeat (2) step();
    chk("pre_reset_run", int'(sw.state_o), 1);
    do_reset();
    step();
    chk("post_reset_idle", int'(sw.state_o), 0);

    // bouncing start is filtered
    for (int k = 0; k < 6; k++) begin
      drive((k % 2 == 0) ? 5'b10000 : 5'b0);
      step();
    end
    drive(5'b0);
    pulses = 0;
    moved = 0;
    repeat (15) begin
      step();
      pulses += int'(sw.tick_o) +
                int'(sw.clear_o) +
                int'(sw.inc_sec_o) +
                int'(sw.inc_min_o);
      if (sw.state_o != 2'd0) moved++;
    end
    chk("bounce_pulses", pulses, 0);
    chk("bounce_state", moved, 0);

    // random levels with random hold lengths
    for (int s = 0; s < 150; s++) begin
      v[4] = ($urandom_range(0, 2) == 0);
      v[3] = 1'($urandom_range(0, 1));
      v[2] = ($urandom_range(0, 15) == 0);
      v[1] = ($urandom_range(0, 2) == 0);
      v[0] = ($urandom_range(0, 2) == 0);
      drive(v);
      repeat ($urandom_range(1, 14)) step();
    end

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1_000_000, giving the debounce stability window in clk cycles.
REQ-002 The block SHALL have parameter TICK_CYCLES, default 100_000_000, giving the clk cycles per 1 Hz tick.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 25_000_000, giving the adjust auto-repeat period in clk cycles.
REQ-004 The block SHALL have port clk, input, width 1: the single system clock; all flops sample on its rising edge.
REQ-005 The block SHALL have port rstn, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have ports start_raw, pause_raw, clear_raw, adj_sec_raw and adj_min_raw, each input, width 1: asynchronous raw switch/button levels.
REQ-007 The block SHALL have port state_o, output, width 2: the current FSM state (IDLE=0, RUN=1, PAUSE=2, ADJUST=3).
REQ-008 The block SHALL have port run_o, output, width 1: high while in RUN.
REQ-009 The block SHALL have port tick_o, output, width 1: one-cycle count-enable pulse to the seconds/minutes counter.
REQ-010 The block SHALL have port clear_o, output, width 1: one-cycle pulse that zeroes the downstream counter.
REQ-011 The block SHALL have ports inc_sec_o and inc_min_o, each output, width 1: one-cycle adjust pulses.

Function
REQ-012 Each raw input SHALL pass a 2-flop synchronizer and then a debouncer whose output changes only after the synchronized value differs from it for DB_CYCLES consecutive cycles; any glitch restarts the count.
REQ-013 A raw level change held stable SHALL appear on the debounced signal exactly DB_CYCLES+2 cycles later.
REQ-014 Rising edges SHALL be detected on debounced start and clear; pause, adj_sec and adj_min SHALL be used as levels.
REQ-015 In IDLE, a start edge SHALL move the FSM to RUN on the next cycle; all other inputs SHALL be ignored.
REQ-016 In RUN, debounced pause high SHALL move the FSM to PAUSE; start edges SHALL be ignored.
REQ-017 In PAUSE, pause low SHALL return the FSM to RUN; otherwise, adj_sec or adj_min high SHALL move it to ADJUST.
REQ-018 In ADJUST, both adj inputs low SHALL return the FSM to PAUSE; pause going low SHALL return it to RUN; exit from ADJUST SHALL take priority over repeat pulses.
REQ-019 A clear edge in any state SHALL force IDLE on the next cycle and pulse clear_o high for exactly one cycle; clear SHALL win over a simultaneous start or pause.
REQ-020 The tick prescaler SHALL count only in RUN and pulse tick_o on its terminal count TICK_CYCLES-1, then wrap to 0.
REQ-021 The prescaler SHALL hold its value in PAUSE/ADJUST so that fractional seconds are preserved, and SHALL reset to 0 in IDLE.
REQ-022 In ADJUST, the first inc pulse SHALL occur on the cycle after entry, followed by a pulse every REPEAT_CYCLES while the input is held; the repeat counter SHALL zero on exit.
REQ-023 With both adj inputs high, only inc_sec_o SHALL pulse (seconds priority); inc_sec_o and inc_min_o SHALL never be high together.
REQ-024 tick_o, clear_o and the inc pulses SHALL be mutually exclusive in any cycle.
REQ-025 Counter widths SHALL be $clog2 of their parameter; counters SHALL never overflow past their terminal value.

Reset
REQ-026 rstn low SHALL immediately force state IDLE, clear all counters, synchronizers and debounced values to 0, and drive run_o, tick_o, clear_o, inc_sec_o, inc_min_o and state_o to 0.
REQ-027 Release of rstn SHALL be followed by normal operation from the first clk edge; no input edge SHALL be inferred from the reset release.

Structure
REQ-028 State encodings SHALL live in the shared stopwatch package/header, alongside the default DB_CYCLES, TICK_CYCLES and REPEAT_CYCLES constants.
REQ-029 One sub-module, sw_debounce (synchronizer plus stability counter, parameter DB_CYCLES), SHALL be instantiated five times.

Verification (DB_CYCLES=4, TICK_CYCLES=10, REPEAT_CYCLES=8)
REQ-030 Start bench: start_raw high for 12 cycles from IDLE -> state_o=RUN 7 cycles after the edge; tick_o pulses 10 cycles later and every 10 cycles thereafter.
REQ-031 Bounce bench: start_raw toggled every cycle for 6 cycles, then low -> no state change and no pulses.
REQ-032 Pause bench: in RUN 15 cycles after a tick, pause_raw high for 30 cycles, then low -> no tick during PAUSE; first tick 5 cycles after re-entering RUN.
REQ-033 Adjust bench: in PAUSE, adj_sec_raw and adj_min_raw held together -> ADJUST; inc_sec_o pulses at entry+1, +9, +17; inc_min_o stays 0.
REQ-034 Clear bench: clear_raw edge during ADJUST -> IDLE next cycle after the debounced edge; clear_o is high 1 cycle; no further inc pulses.
REQ-035 Reset bench: rstn low asynchronously mid-RUN -> all outputs are 0 before the next clk edge; state_o=IDLE after release.
